// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared widths, reset PC, PC increment and FIFO depth for the fetch queue.
package if_prefetch_queue_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS = 32;
  localparam int IFQ_DEPTH = 4;
  localparam int PC_INC = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h1C00_0000;
endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: synchronous in-order FIFO with push/pop/clear, occupancy count and full/empty flags.
module ifq_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W = INST_ADDR_BUS + INST_BUS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetch with credit-limited issue, in-order buffering and flush/redirect.
// Define IFQ_BYPASS_EN to forward a response straight to the decode side when the queue is empty.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int DATA_W = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              inst_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, head_pc, flush_tgt;
  logic [DATA_W-1:0] head_inst;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic full, empty, grant, live, bypass, push, pop;
  assign flush_tgt = {flush_pc_i[ADDR_W-1:2], 2'b00};
  assign grant = mem_req_o & mem_gnt_i;
  assign live = mem_rvalid_i & (drop_cnt == '0) & ~flush_i;
`ifdef IFQ_BYPASS_EN
  assign bypass = live & empty;
`else
  assign bypass = 1'b0;
`endif
  assign push = live & ~full & ~(bypass & inst_ready_i);
  assign pop = ~empty & inst_ready_i & ~flush_i;
  // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
  assign mem_req_o = ~rst & ~flush_i & (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_pc;
  assign inst_valid_o = ~empty | bypass;
  assign inst_o = bypass ? mem_rdata_i : head_inst;
  assign pc_o = bypass ? resp_pc : head_pc;
  ifq_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush_i),
    .push(push),
    .pop(pop),
    .din({resp_pc, mem_rdata_i}),
    .dout({head_pc, head_inst}),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // After a redirect every in-flight response is stale; they keep their credits until they return.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid_i);
      fetch_pc <= flush_i ? flush_tgt : grant ? fetch_pc + ADDR_W'(PC_INC) : fetch_pc;
      resp_pc <= flush_i ? flush_tgt : live ? resp_pc + ADDR_W'(PC_INC) : resp_pc;
      drop_cnt <= flush_i ? outstanding - CW'(mem_rvalid_i)
                : (mem_rvalid_i && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: randomized bench with an in-order memory model and a queue-based reference of the fetch stream.
module tb_if_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h1C00_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, mem_req_o, mem_gnt_i, mem_rvalid_i, flush_i, inst_valid_o, inst_ready_i;
  logic [31:0] mem_addr_o, mem_rdata_i, flush_pc_i, inst_o, pc_o;
  always #5 clk = ~clk;
  if_prefetch_queue dut (
    .clk(clk),
    .rst(rst),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .flush_i(flush_i),
    .flush_pc_i(flush_pc_i),
    .inst_valid_o(inst_valid_o),
    .inst_o(inst_o),
    .pc_o(pc_o),
    .inst_ready_i(inst_ready_i)
  );
  typedef struct {
    logic [31:0] addr;
    bit stale;
    int due;
  } req_t;
  req_t infl[$];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_fetch;
  int errors = 0, checks = 0, cyc = 0, lat_min = 1, lat_max = 1;
  bit g_grant, g_pop, g_valid;
  logic [31:0] g_pop_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  // One clock cycle: drive memory/consumer inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input bit fl, input logic [31:0] fpc, input bit rdy, input int gpct);
    bit rv, live, byp, exp_req, exp_valid;
    logic [31:0] exp_pc;
    req_t r;
    rv = infl.size() > 0 && infl[0].due <= cyc;
    live = rv && !infl[0].stale && !fl;
    flush_i = fl;
    flush_pc_i = fpc;
    inst_ready_i = rdy;
    mem_gnt_i = $urandom_range(99) < gpct;
    mem_rvalid_i = rv;
    mem_rdata_i = rv ? word(infl[0].addr) : $urandom;
    byp = BYP && live && fifo_q.size() == 0;
    exp_valid = fifo_q.size() > 0 || byp;
    exp_pc = fifo_q.size() > 0 ? fifo_q[0] : byp ? infl[0].addr : 32'h0;
    exp_req = !fl && (fifo_q.size() + infl.size() < DEPTH);
    #1;
    checks++;
    if (mem_req_o !== exp_req) begin
      errors++;
      $display("FAIL req: cycle %0d mem_req_o=%b expected %b", cyc, mem_req_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (mem_addr_o !== exp_fetch) begin
        errors++;
        $display("FAIL addr: cycle %0d mem_addr_o=%h expected %h", cyc, mem_addr_o, exp_fetch);
      end
    end
    checks++;
    if (inst_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL valid: cycle %0d inst_valid_o=%b expected %b", cyc, inst_valid_o, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (pc_o !== exp_pc || inst_o !== word(exp_pc)) begin
        errors++;
        $display("FAIL head: cycle %0d pc_o=%h inst_o=%h expected pc %h inst %h", cyc, pc_o, inst_o, exp_pc, word(exp_pc));
      end
    end
    g_valid = inst_valid_o;
    g_grant = mem_req_o === 1'b1 && mem_gnt_i;
    g_pop = exp_valid && rdy && !fl;
    g_pop_pc = exp_pc;
    if (rv) r = infl.pop_front();
    if (fl) begin
      fifo_q.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      exp_fetch = {fpc[31:2], 2'b00};
    end else begin
      if (g_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (live && !(byp && rdy)) fifo_q.push_back(r.addr);
      if (g_grant) begin
        infl.push_back('{exp_fetch, 1'b0, cyc + int'($urandom_range(lat_max, lat_min))});
        exp_fetch += 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    flush_pc_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    inst_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 4;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: mem_req_o=%b expected 0", mem_req_o); end
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: inst_valid_o=%b expected 0", inst_valid_o); end
    if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: inst_o=%h expected 0", inst_o); end
    if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: pc_o=%h expected 0", pc_o); end
    rst = 1'b0;
    infl.delete();
    fifo_q.delete();
    exp_fetch = RPC;
  endtask

  task automatic test_stream();
    int first_g = -1, first_v = -1, pops = 0;
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      if (first_g < 0 && g_grant) first_g = cyc - 1;
      if (first_v < 0 && g_valid) first_v = cyc - 1;
      pops += int'(g_pop);
    end
    checks += 2;
    if (first_v - first_g !== (BYP ? 1 : 2)) begin
      errors++;
      $display("FAIL stream_latency: valid %0d cycles after first grant, expected %0d", first_v - first_g, BYP ? 1 : 2);
    end
    if (pops < 20) begin errors++; $display("FAIL stream_rate: %0d words delivered, expected at least 20", pops); end
  endtask

  task automatic test_stall();
    int grants = 0;
    bit seen = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 0);
    cycle(1'b1, 32'h1C00_1000, 1'b0, 100);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 100);
      grants += int'(g_grant);
    end
    checks++;
    if (grants != DEPTH) begin errors++; $display("FAIL stall_grants: %0d grants, expected %0d", grants, DEPTH); end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      if (g_pop && !seen) begin
        seen = 1;
        checks++;
        if (g_pop_pc !== 32'h1C00_1000) begin errors++; $display("FAIL stall_first: pc %h expected 1c001000", g_pop_pc); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_drain: no word delivered after stall, expected delivery"); end
  endtask

  task automatic test_flush_lat3();
    int grants = 0;
    bit seen = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 0);
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      grants += int'(g_grant);
    end
    checks++;
    if (grants != 3) begin errors++; $display("FAIL lat3_grants: %0d grants, expected 3", grants); end
    cycle(1'b1, 32'h1C00_0100, 1'b1, 100);
    for (int i = 0; i < 25; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      if (g_pop && !seen) begin
        seen = 1;
        checks++;
        if (g_pop_pc !== 32'h1C00_0100) begin errors++; $display("FAIL lat3_first: pc %h expected 1c000100", g_pop_pc); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL lat3_deliver: no word after redirect, expected delivery"); end
  endtask

  task automatic test_flush_collide();
    bit found = 0, seen = 0;
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (fifo_q.size() > 0 && infl.size() > 0 && infl[0].due <= cyc && !infl[0].stale) begin
        cycle(1'b1, 32'h1C00_2003, 1'b1, 100);
        found = 1;
      end else cycle(1'b0, 32'h0, 1'b1, 100);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL collide_setup: push/pop/rvalid cycle never reached, expected one"); end
    cycle(1'b0, 32'h0, 1'b1, 100);
    checks++;
    if (g_valid !== 1'b0) begin errors++; $display("FAIL collide_empty: inst_valid_o=%b after flush, expected 0", g_valid); end
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      if (g_pop && !seen) begin
        seen = 1;
        checks++;
        if (g_pop_pc !== 32'h1C00_2000) begin errors++; $display("FAIL collide_first: pc %h expected 1c002000", g_pop_pc); end
      end
    end
  endtask

  task automatic test_back_to_back_flush();
    bit seen = 0;
    lat_min = 1;
    lat_max = 2;
    repeat (5) cycle(1'b0, 32'h0, 1'b1, 100);
    cycle(1'b1, 32'h0000_0200, 1'b1, 100);
    cycle(1'b1, 32'h0000_0300, 1'b1, 100);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 100);
      if (g_pop && !seen) begin
        seen = 1;
        checks++;
        if (g_pop_pc !== 32'h0000_0300) begin errors++; $display("FAIL b2b_first: pc %h expected 00000300", g_pop_pc); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_deliver: no word after double flush, expected delivery"); end
  endtask

  task automatic test_random();
    bit fl;
    logic [31:0] fpc;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      fl = $urandom_range(99) < 4;
      fpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(fl, fpc, $urandom_range(99) < 60, 70);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_flush_lat3();
    test_flush_collide();
    test_back_to_back_flush();
    test_random();
    test_reset();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
